vc_packet_scheduler: RTL
========================

Name: vc_packet_scheduler

Overview:
- Injection-side scheduler for one router/NI output link.
- Accepts packet descriptors (src, dest, vc, num_flits) into one pending slot per virtual channel.
- Picks a VC round-robin, but only among VCs holding a pending descriptor and at least one downstream credit.
- Serialises the winning packet into head/body/tail flits on a valid/ready link; tracks per-VC downstream credits.

Parameters:
- NUM_VC, 8, number of virtual channels (1..8; VC index carried on 3 bits).
- CREDITS, 4, downstream buffer depth per VC; credit counter reset value and saturation limit.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- desc_valid  input  1  descriptor offered.
- desc_ready  output  1  descriptor accepted when desc_valid && desc_ready at the clock edge.
- desc_src  input  10  source node id.
- desc_dest  input  10  destination node id.
- desc_vc  input  3  target VC.
- desc_num_flits  input  16  packet length in flits.
- credit_valid  input  1  one credit returned this cycle.
- credit_vc  input  3  VC of returned credit.
- flit_valid  output  1  flit presented.
- flit_ready  input  1  downstream accepts the flit.
- flit_vc  output  3  VC of current flit.
- flit_head  output  1  first flit of packet.
- flit_tail  output  1  last flit of packet.
- flit_src  output  10  packet source.
- flit_dest  output  10  packet destination.
- flit_seq  output  16  flit index within packet, 0-based.
- credit_err  output  1  sticky; set on credit overflow or an out-of-range credit_vc.

Behaviour:
- Reset (synchronous, active-high, also mid-packet): all slots empty, all credit counters = CREDITS, state IDLE, RR pointer = NUM_VC-1 (VC0 gets first priority), seq = 0, credit_err = 0. Effect on the flit outputs:
  - flit_valid = 0.
  - flit_head, flit_tail, flit_vc, flit_src, flit_dest and flit_seq = 0.
  - Any in-flight packet is dropped.
- Descriptor intake:
  - desc_ready = (desc_vc < NUM_VC) && slot[desc_vc] empty; combinational from registered state.
  - On accept, the slot stores src, dest and len; len = max(desc_num_flits, 1), so 0 is treated as a single-flit packet.
  - A slot freed in cycle T is not reusable until T+1.
- Credits:
  - Each flit fire (flit_valid && flit_ready) on VC v decrements cnt[v].
  - credit_valid on v increments cnt[v].
  - Both in the same cycle on the same VC: cnt unchanged.
  - An increment at cnt = CREDITS saturates and sets credit_err.
  - credit_vc >= NUM_VC is ignored and sets credit_err.
- FSM IDLE:
  - Eligible VC = slot valid && cnt > 0.
  - Choose the first eligible VC searching from ptr+1 modulo NUM_VC.
  - On a grant: cur <- v, ptr <- v, seq <- 0, go to SEND next edge. No eligible VC: stay IDLE.
- FSM SEND: outputs are combinational from registers.
  - flit_valid = (cnt[cur] > 0); flit_head = (seq == 0); flit_tail = (seq == len-1).
  - flit_vc, flit_src and flit_dest come from slot[cur].
  - On a fire: seq++.
  - On a tail fire: slot[cur] cleared, seq <- 0, go IDLE.
  - Packets are never interleaved: the link stays locked to cur until its tail fires, stalling while cnt[cur] = 0.
- Outputs in IDLE: all flit_* = 0.
- Latency:
  - Descriptor accepted at edge T → slot valid T+1 → grant at edge T+1 → first flit_valid during cycle T+2.
  - One idle bubble cycle between packets (tail fire → IDLE → grant).
- flit_valid does not drop while flit_ready is low, since credits only increase while stalled.

Optional Feature:
- Macro: VC_PACKET_SCHEDULER_STATS_EN.
- Defined: adds outputs stat_pkts[31:0] and stat_flits[31:0].
  - stat_flits increments per flit fire; stat_pkts increments per tail fire.
  - Both wrap at 2^32 and are cleared by rst.
- Undefined: ports still exist but are driven constant 0; no counter logic.

Test Plan:
- Single packet: rst, then descriptor vc=2, src=5, dest=9, num_flits=3 with flit_ready=1 → flits in cycles T+2..T+4 with seq 0,1,2; head only on seq 0, tail only on seq 2; slot[2] empty afterwards, cnt[2]=1.
- Round-robin: descriptors on VC0, VC1 and VC3 (1 flit each) pending simultaneously → served in order 0,1,3 with one bubble between packets; then a new VC0 packet plus a pending VC3 packet → VC0 is served before the VC3 packet that follows it.
- Credit stall: CREDITS=4, vc=1 packet of 6 flits, no credit return → 4 flits, then flit_valid=0. Credit on vc 1 → flit 4 is sent; a second credit → tail.
- Zero length and duplicates: num_flits=0 → one flit with head=tail=1. A second descriptor on an occupied VC → desc_ready=0 until the tail fires.
- Credit errors: credit_valid on vc=3 when cnt[3]=4 → cnt stays 4 and credit_err=1 sticky. credit_vc=7 with NUM_VC=4 → credit_err=1.
- Reset mid-packet: assert rst during seq=2 of a 5-flit packet → next cycle flit_valid=0, all slots empty, all cnt=CREDITS; stats (if enabled) = 0.

Source files
------------

// File: rtl/vc_packet_scheduler.sv
// vc_packet_scheduler: injection-side scheduler for one output link.
// Each VC holds at most one pending packet descriptor. A round-robin arbiter
// picks among VCs that have a pending packet and at least one downstream
// credit. The winning packet is then sent as head/body/tail flits, and the
// link stays on that VC until its tail flit has been sent.
// Optional build macro VC_PACKET_SCHEDULER_STATS_EN enables the packet and
// flit counters. When it is undefined, stat_pkts/stat_flits are tied to 0.
//
// Handshake rule, used on every valid/ready pair here: a transfer happens at a
// rising edge exactly when valid && ready are both high. Once flit_valid is
// raised it stays high, with stable flit fields, until the flit is accepted.
module vc_packet_scheduler #(
  parameter int NUM_VC  = 8,
  parameter int CREDITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        desc_valid,
  output logic        desc_ready,
  input  logic [9:0]  desc_src,
  input  logic [9:0]  desc_dest,
  input  logic [2:0]  desc_vc,
  input  logic [15:0] desc_num_flits,
  input  logic        credit_valid,
  input  logic [2:0]  credit_vc,
  output logic        flit_valid,
  input  logic        flit_ready,
  output logic [2:0]  flit_vc,
  output logic        flit_head,
  output logic        flit_tail,
  output logic [9:0]  flit_src,
  output logic [9:0]  flit_dest,
  output logic [15:0] flit_seq,
  output logic        credit_err,
  output logic [31:0] stat_pkts,
  output logic [31:0] stat_flits,
  output logic [0:0]  dbg_state
);

  // The per-VC arrays are sized for the full 3-bit VC space. Entries at or
  // above NUM_VC are never filled, never granted and never credited.
  localparam int MAX_VC = 8;
  localparam int CW     = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]        state;
  logic [2:0]        ptr;
  logic [2:0]        cur;
  logic [15:0]       seq_q;

  logic [MAX_VC-1:0] slot_valid;
  logic [9:0]        slot_src  [MAX_VC];
  logic [9:0]        slot_dest [MAX_VC];
  logic [15:0]       slot_len  [MAX_VC];
  logic [CW-1:0]     cnt       [MAX_VC];

  logic              desc_fire;
  logic [15:0]       desc_len;
  logic              fire;
  logic              tail_fire;
  logic [MAX_VC-1:0] eligible;
  logic              grant_found;
  logic [2:0]        grant_vc;
  logic [2:0]        idx;
  logic [MAX_VC-1:0] cred_inc;
  logic [MAX_VC-1:0] cred_dec;
  logic              sat_err;
  logic              credit_bad;

  assign dbg_state = state;

  // Descriptor intake: ready only for an in-range VC whose slot is empty.
  always_comb begin
    desc_ready = 1'b0;
    for (int v = 0; v < MAX_VC; v++) begin
      if (v < NUM_VC && desc_vc == 3'(v) && !slot_valid[v]) desc_ready = 1'b1;
    end
  end

  assign desc_fire = desc_valid && desc_ready;
  // A packet length of zero is treated as a single-flit packet.
  assign desc_len  = (desc_num_flits == 16'd0) ? 16'd1 : desc_num_flits;

  // A VC can be granted when it has a pending packet and at least one credit.
  always_comb begin
    for (int v = 0; v < MAX_VC; v++) begin
      eligible[v] = (v < NUM_VC) && slot_valid[v] && (cnt[v] != '0);
    end
  end

  // Round-robin search: look at VCs starting from ptr+1 and wrap around.
  always_comb begin
    grant_found = 1'b0;
    grant_vc    = 3'd0;
    idx         = 3'd0;
    for (int i = 1; i <= MAX_VC; i++) begin
      idx = 3'((int'(ptr) + i) % NUM_VC);
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_vc    = idx;
      end
    end
  end

  // Flit outputs come only from registers. In IDLE every flit output is 0.
  always_comb begin
    flit_valid = 1'b0;
    flit_vc    = 3'd0;
    flit_head  = 1'b0;
    flit_tail  = 1'b0;
    flit_src   = 10'd0;
    flit_dest  = 10'd0;
    flit_seq   = 16'd0;
    if (state == S_SEND) begin
      flit_valid = (cnt[cur] != '0);
      flit_vc    = cur;
      flit_head  = (seq_q == 16'd0);
      flit_tail  = (seq_q == slot_len[cur] - 16'd1);
      flit_src   = slot_src[cur];
      flit_dest  = slot_dest[cur];
      flit_seq   = seq_q;
    end
  end

  assign fire      = flit_valid && flit_ready;
  assign tail_fire = fire && flit_tail;

  // Per-VC credit events. Credits returned for out-of-range VCs are flagged.
  always_comb begin
    sat_err = 1'b0;
    for (int v = 0; v < MAX_VC; v++) begin
      cred_inc[v] = credit_valid && (credit_vc == 3'(v)) && (v < NUM_VC);
      cred_dec[v] = fire && (cur == 3'(v));
      if (cred_inc[v] && !cred_dec[v] && cnt[v] == CRED_MAX) sat_err = 1'b1;
    end
    credit_bad = credit_valid && (int'(credit_vc) >= NUM_VC);
  end

  // Credit counters: a return and a send on the same VC cancel out.
  // An overflowing return saturates the counter and sets the sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < MAX_VC; v++) cnt[v] <= CRED_MAX;
      credit_err <= 1'b0;
    end else begin
      for (int v = 0; v < MAX_VC; v++) begin
        if (cred_inc[v] && !cred_dec[v]) begin
          if (cnt[v] != CRED_MAX) cnt[v] <= cnt[v] + CW'(1);
        end else if (cred_dec[v] && !cred_inc[v]) begin
          cnt[v] <= cnt[v] - CW'(1);
        end
      end
      if (sat_err || credit_bad) credit_err <= 1'b1;
    end
  end

  // Pending slots: filled when a descriptor is accepted, cleared when the
  // packet's tail flit is sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid <= '0;
      for (int v = 0; v < MAX_VC; v++) begin
        slot_src[v]  <= 10'd0;
        slot_dest[v] <= 10'd0;
        slot_len[v]  <= 16'd0;
      end
    end else begin
      for (int v = 0; v < MAX_VC; v++) begin
        if (desc_fire && desc_vc == 3'(v)) begin
          slot_valid[v] <= 1'b1;
          slot_src[v]   <= desc_src;
          slot_dest[v]  <= desc_dest;
          slot_len[v]   <= desc_len;
        end else if (tail_fire && cur == 3'(v)) begin
          slot_valid[v] <= 1'b0;
        end
      end
    end
  end

  // Main state machine: grant a VC in IDLE, then stay on it in SEND until
  // its tail flit has been sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= 3'(NUM_VC - 1);
      cur   <= 3'd0;
      seq_q <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            cur   <= grant_vc;
            ptr   <= grant_vc;
            seq_q <= 16'd0;
            state <= S_SEND;
          end
        end
        default: begin
          if (tail_fire) begin
            seq_q <= 16'd0;
            state <= S_IDLE;
          end else if (fire) begin
            seq_q <= seq_q + 16'd1;
          end
        end
      endcase
    end
  end

`ifdef VC_PACKET_SCHEDULER_STATS_EN
  // Free-running statistics, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkts  <= 32'd0;
      stat_flits <= 32'd0;
    end else begin
      if (fire)      stat_flits <= stat_flits + 32'd1;
      if (tail_fire) stat_pkts  <= stat_pkts + 32'd1;
    end
  end
`else
  assign stat_pkts  = 32'd0;
  assign stat_flits = 32'd0;
`endif

endmodule
